// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Purpose  : Forwarding and load-use hazard unit for a 5-stage pipeline.
//            - Drives per-operand ALU mux selects from EX/MEM and MEM/WB.
//            - Detects load-use hazards and inserts LD_LAT bubbles through a
//              small stall FSM, so that multi-cycle data memory is supported.
// Ports    : clk, rst           clock, synchronous active-high reset
//            id_src/_vld        ID-stage source registers and read flags
//            ex_src/_vld        ID/EX source registers and read flags
//            ex_*, mem_*, wb_*  destination and write flags per stage
//            flush              branch/jump flush from EX
//            fwd_sel            2 bits per operand: 00 regfile, 10 EX/MEM,
//                               01 MEM/WB
//            stall_pc, stall_ifid, bubble_idex   stall controls
//            hz_busy            registered: FSM is in STALL
//            stall_cnt          (FWD_STALL_CNT_EN only) saturating count of
//                               bubble cycles
// Options  : define FWD_STALL_CNT_EN to add the stall_cnt port and counter.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
  parameter int REG_W    = 4,
  parameter int NUM_SRC  = 2,
  parameter int LD_LAT   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_vld,
  input  logic [NUM_SRC*REG_W-1:0] ex_src,
  input  logic [NUM_SRC-1:0]       ex_src_vld,
  input  logic [REG_W-1:0]         ex_wr_reg,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_read,
  input  logic [REG_W-1:0]         mem_wr_reg,
  input  logic                     mem_reg_write,
  input  logic [REG_W-1:0]         wb_wr_reg,
  input  logic                     wb_reg_write,
  input  logic                     flush,
  output logic [2*NUM_SRC-1:0]     fwd_sel,
  output logic                     stall_pc,
  output logic                     stall_ifid,
  output logic                     bubble_idex,
  output logic                     hz_busy
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam logic [3:0] c_LAT_M1 = 4'(LD_LAT - 1);
  localparam logic       c_MULTI  = (LD_LAT > 1);
  localparam logic       c_ZHARD  = (ZERO_REG != 0);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;
  logic               w_stall;
  logic               w_detect;
  logic               w_ex_ok;
  logic               w_mem_ok;
  logic               w_wb_ok;
  logic [NUM_SRC-1:0] w_id_hit;

  // A destination is a legal forwarding/stall source unless it is the
  // hardwired zero register.
  assign w_ex_ok  = !c_ZHARD || (ex_wr_reg  != '0);
  assign w_mem_ok = mem_reg_write && (!c_ZHARD || (mem_wr_reg != '0));
  assign w_wb_ok  = wb_reg_write  && (!c_ZHARD || (wb_wr_reg  != '0));

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_W-1:0] w_ex_src;
    logic [REG_W-1:0] w_id_src;
    logic             w_mem_hit;
    logic             w_wb_hit;

    assign w_ex_src  = ex_src[i*REG_W +: REG_W];
    assign w_id_src  = id_src[i*REG_W +: REG_W];
    assign w_mem_hit = ex_src_vld[i] && w_mem_ok && (mem_wr_reg == w_ex_src);
    assign w_wb_hit  = ex_src_vld[i] && w_wb_ok  && (wb_wr_reg  == w_ex_src);

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    assign fwd_sel[2*i +: 2] = rst       ? 2'b00 :
                               w_mem_hit ? 2'b10 :
                               w_wb_hit  ? 2'b01 : 2'b00;

    assign w_id_hit[i] = id_src_vld[i] && (w_id_src == ex_wr_reg);
  end

  assign w_detect = ex_mem_read && ex_reg_write && w_ex_ok && (|w_id_hit);

  // Next state and stall request. The first bubble comes combinationally from
  // IDLE; the FSM only covers the remaining LD_LAT-1 bubbles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_stall = w_detect;
          if (w_detect && c_MULTI) begin
            w_state_nxt = ST_STALL;
            w_cnt_nxt   = c_LAT_M1;
          end
        end
        ST_STALL: begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign stall_pc    = w_stall && !rst;
  assign stall_ifid  = w_stall && !rst;
  assign bubble_idex = w_stall && !rst;
  assign hz_busy     = (r_state == ST_STALL);

`ifdef FWD_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (bubble_idex && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
